// File: rtl/booth_seq_mul_pkg.sv
// Shared constants for the radix-4 Booth sequential multiplier:
// FSM state encodings, Booth partial-product select codes and the
// three-bit recoding function.
package booth_seq_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_POS1 = 3'd1,
        SEL_POS2 = 3'd2,
        SEL_NEG1 = 3'd3,
        SEL_NEG2 = 3'd4
    } booth_sel_t;

    // Radix-4 Booth recoding of {q[i+1], q[i], q[i-1]} into a digit select.
    function automatic booth_sel_t booth_decode(input logic [2:0] bits);
        booth_sel_t sel;
        case (bits)
            3'b000, 3'b111: sel = SEL_ZERO;
            3'b001, 3'b010: sel = SEL_POS1;
            3'b011:         sel = SEL_POS2;
            3'b100:         sel = SEL_NEG2;
            3'b101, 3'b110: sel = SEL_NEG1;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Combinational Booth digit recoder: turns the low three accumulator bits
// into a W-bit partial product plus carry-in. Negative digits are produced
// as the inverted operand with carry-in 1, so the adder completes the
// two's-complement negation.
module booth_recode
    import booth_seq_mul_pkg::*;
#(
    parameter int W = 34
) (
    input  logic [2:0]   bits,
    input  logic [W-1:0] mcand,
    output logic [W-1:0] pp,
    output logic         cin
);

    booth_sel_t   sel_s;
    logic [W-1:0] mcand_x2_s;

    assign mcand_x2_s = {mcand[W-2:0], 1'b0};

    // Select the partial product and carry-in for the current Booth digit.
    always_comb begin
        sel_s = booth_decode(bits);
        pp    = {W{1'b0}};
        cin   = 1'b0;
        case (sel_s)
            SEL_ZERO: begin pp = {W{1'b0}};  cin = 1'b0; end
            SEL_POS1: begin pp = mcand;       cin = 1'b0; end
            SEL_POS2: begin pp = mcand_x2_s;  cin = 1'b0; end
            SEL_NEG1: begin pp = ~mcand;      cin = 1'b1; end
            SEL_NEG2: begin pp = ~mcand_x2_s; cin = 1'b1; end
            default:  begin pp = {W{1'b0}};  cin = 1'b0; end
        endcase
    end

endmodule

// File: rtl/ripple_carry_adder.sv
// Generic W-bit ripple-carry adder, sum = a + b + cin (modulo 2^W).
module ripple_carry_adder #(
    parameter int W = 34
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin
        logic c;
        c   = cin;
        sum = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential signed multiplier, radix-4 Booth, two multiplier bits per
// clock. Accumulator layout (2*BITS+3 bits):
//   [2*BITS+2 : BITS+1]  running partial sum (BITS+2 bits, two guard bits)
//   [BITS     : 1]       remaining multiplier bits / low product bits
//   [0]                  Booth guard bit
// After BITS/2 steps the exact product sits in [2*BITS : 1].
module booth_seq_mul
    import booth_seq_mul_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [BITS-1:0] multiplicand,
    input  logic [BITS-1:0] multiplier,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] product_hi,
    output logic [BITS-1:0] product_lo
);

    localparam int EW = BITS + 2;
    localparam int AW = 2 * BITS + 3;
    localparam int CW = $clog2(BITS / 2 + 1);

    state_t         state_r;
    logic [EW-1:0]  m_ext_r;
    logic [AW-1:0]  acc_r;
    logic [CW-1:0]  cnt_r;

    logic [EW-1:0]  pp_s;
    logic           cin_s;
    logic [EW-1:0]  sum_s;
    logic [AW-1:0]  acc_next_s;
    logic           last_s;

    booth_recode #(.W(EW)) u_recode (
        .bits  (acc_r[2:0]),
        .mcand (m_ext_r),
        .pp    (pp_s),
        .cin   (cin_s)
    );

    ripple_carry_adder #(.W(EW)) u_adder (
        .a   (acc_r[AW-1 -: EW]),
        .b   (pp_s),
        .cin (cin_s),
        .sum (sum_s)
    );

    // Arithmetic shift right by two of {new partial sum, low accumulator bits}.
    assign acc_next_s = {{2{sum_s[EW-1]}}, sum_s, acc_r[BITS:2]};
    assign last_s     = (cnt_r == CW'(1));

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r    <= ST_IDLE;
            m_ext_r    <= {EW{1'b0}};
            acc_r      <= {AW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            product_hi <= {BITS{1'b0}};
            product_lo <= {BITS{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        m_ext_r <= {{2{multiplicand[BITS-1]}}, multiplicand};
                        acc_r   <= {{EW{1'b0}}, multiplier, 1'b0};
                        cnt_r   <= CW'(BITS / 2);
                        state_r <= ST_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (last_s) begin
                        product_hi <= acc_next_s[2*BITS:BITS+1];
                        product_lo <= acc_next_s[BITS:1];
                        state_r    <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul (BITS=32): directed handshake and
// corner cases followed by randomized operands, compared against a plain
// 64-bit signed multiply.
module tb_booth_seq_mul;

    localparam int BITS = 32;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int tests = 0;
    int fails = 0;

    booth_seq_mul #(.BITS(BITS)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        longint a;
        longint b;
        a = $signed(m);
        b = $signed(q);
        return 64'(a * b);
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = 32'($urandom);
        endcase
        return v;
    endfunction

    task automatic launch(input logic [31:0] m, input logic [31:0] q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles (and busy cycles) from the current sample point until done.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        int          bcyc;
        logic        seen_done;
        logic [31:0] m;
        logic [31:0] q;

        clr          = 1'b1;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(product_hi), 64'd0);
        check("reset lo", 64'(product_lo), 64'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        // 97 x 7: latency, busy width, product, single-cycle done
        launch(32'd97, 32'd7);
        wait_done(cyc, bcyc);
        check("97x7 latency", 64'(cyc), 64'd16);
        check("97x7 busy cycles", 64'(bcyc), 64'd16);
        check("97x7 hi", 64'(product_hi), 64'h0);
        check("97x7 lo", 64'(product_lo), 64'h2A7);
        check("97x7 busy at done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("done pulse width", 64'(done), 64'd0);
        check("idle busy", 64'(busy), 64'd0);

        // signed corners with fixed expectations
        launch(-32'sd3, 32'd5);
        wait_done(cyc, bcyc);
        check("-3x5", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        launch(32'h8000_0000, 32'h8000_0000);
        wait_done(cyc, bcyc);
        check("MINxMIN", {product_hi, product_lo}, 64'h4000_0000_0000_0000);
        launch(32'h7FFF_FFFF, 32'h8000_0000);
        wait_done(cyc, bcyc);
        check("MAXxMIN", {product_hi, product_lo}, 64'hC000_0000_8000_0000);

        // start while busy is ignored; operands latched; old product held
        launch(32'd6, 32'd7);
        wait_done(cyc, bcyc);
        check("6x7 lo", 64'(product_lo), 64'd42);
        launch(32'd2, 32'd3);
        repeat (4) begin @(posedge clk); #1; end
        start        = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        check("busy mid run", 64'(busy), 64'd1);
        check("held lo mid run", 64'(product_lo), 64'd42);
        @(posedge clk); #1;
        start = 1'b0;
        check("held lo after ignored start", 64'(product_lo), 64'd42);
        wait_done(cyc, bcyc);
        check("ignored start remaining latency", 64'(cyc), 64'd11);
        check("2x3 product", {product_hi, product_lo}, 64'd6);
        @(posedge clk); #1;
        check("no relaunch after ignored start", 64'(busy), 64'd0);

        // back-to-back with start held high across done
        start        = 1'b1;
        multiplicand = 32'd1234;
        multiplier   = -32'sd56;
        @(posedge clk); #1;
        multiplicand = -32'sd777;
        multiplier   = 32'd31337;
        wait_done(cyc, bcyc);
        check("b2b first product", {product_hi, product_lo}, ref_mul(32'd1234, -32'sd56));
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b busy after done", 64'(busy), 64'd1);
        check("b2b done dropped", 64'(done), 64'd0);
        wait_done(cyc, bcyc);
        check("b2b second latency", 64'(cyc), 64'd16);
        check("b2b second product", {product_hi, product_lo}, ref_mul(-32'sd777, 32'd31337));

        // clr mid-run
        launch(32'd12345, 32'd678);
        repeat (7) begin @(posedge clk); #1; end
        clr = 1'b1;
        #1;
        check("clr busy", 64'(busy), 64'd0);
        check("clr done", 64'(done), 64'd0);
        check("clr hi", 64'(product_hi), 64'd0);
        check("clr lo", 64'(product_lo), 64'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("no done after clr", 64'(seen_done), 64'd0);
        launch(32'd100, -32'sd100);
        wait_done(cyc, bcyc);
        check("post clr latency", 64'(cyc), 64'd16);
        check("post clr product", {product_hi, product_lo}, ref_mul(32'd100, -32'sd100));

        // randomized operands
        for (int i = 0; i < 500; i++) begin
            m = pick_operand();
            q = pick_operand();
            launch(m, q);
            wait_done(cyc, bcyc);
            check("random product", {product_hi, product_lo}, ref_mul(m, q));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_seq_mul.md
# booth_seq_mul

Sequential signed multiplier that uses radix-4 Booth recoding and retires two multiplier bits per clock. It is the multiply counterpart to the combinational array divider in the ALU datapath. It produces the full double-width product as separate HI and LO halves, for the MUL instruction's HI/LO register writeback. It trades latency for area with a start/busy/done handshake, so the control unit can stall while it runs.

## Interface
- BITS, 32, operand width; must be even and ≥ 4
- clk  input  1  rising-edge clock
- clr  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE or DONE
- multiplicand  input  BITS  signed two's-complement operand M
- multiplier  input  BITS  signed two's-complement operand Q
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the product becomes valid
- product_hi  output  BITS  upper half of the signed 2·BITS product
- product_lo  output  BITS  lower half of the signed 2·BITS product

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE when the digit counter reaches its last digit.
  - DONE→RUN on start, otherwise DONE→IDLE.
- On an accepted start:
  - Latch M, sign-extended to BITS+2.
  - Load the accumulator with {BITS+2 zeros, Q, 1'b0} (appended zero for Booth).
  - Load the digit counter with BITS/2.
- Each RUN cycle does one Booth step:
  - Recode the low three accumulator bits: 000/111→0, 001/010→+M, 011→+2M, 100→−2M, 101/110→−M.
  - Add the selected partial product to the upper BITS+2 bits. −M and −2M are formed as inverted operand plus carry-in 1.
  - Arithmetic-shift the whole accumulator right by 2.
  - Decrement the counter.
- Width rules:
  - The partial-product path is BITS+2 bits wide, so ±2M never overflows, including M = −2^(BITS−1).
  - The final 2·BITS product is exact; no overflow flag exists.
- On RUN→DONE, product_hi and product_lo load from the accumulator (discarding the Booth guard bit and the top two guard bits).
- product_hi and product_lo hold their value until the next RUN→DONE transition. During RUN they show the previous result, never partial sums.
- start while busy=1 is ignored. Operand changes during RUN have no effect, because the operands are latched.
- clr asserted at any time, including mid-RUN, resets immediately:
  - State goes to IDLE.
  - Counter, accumulator, latched operands, product_hi and product_lo all go to 0.
  - busy=0 and done=0, and no done pulse follows.
- Reset values: busy=0, done=0, product_hi=0, product_lo=0.

## Timing
- Let E0 be the edge that samples start=1.
- busy is high from after E0 through E(BITS/2). For BITS=32 that is 16 cycles.
- E(BITS/2) performs the final step and the DONE transition. done is high and the product is valid for exactly the one cycle after E(BITS/2).
- Latency from the start edge to valid product is BITS/2 cycles.
- Back-to-back operation: start=1 while done=1 launches the next operation at that edge. busy rises in the cycle after done, with no idle bubble.
- busy and done are registered and decoded directly from state; they have no combinational path from start.
- The adder is a single BITS+2-bit adder per cycle. The critical path is recode mux, then adder, then shifter.

## Structure
- The shared constants package holds:
  - FSM state encodings (IDLE, RUN, DONE).
  - The Booth select codes (ZERO, POS1, POS2, NEG1, NEG2).
- One sub-module is natural: booth_recode. It is combinational, maps 3 bits to a select code, and outputs the BITS+2-bit partial product plus a carry-in.
- The adder reuses the existing ripple_carry_adder, instantiated with BITS+2.

## Test plan
- 97 × 7, start pulse, BITS=32 → done exactly 16 cycles later with hi=0x00000000, lo=0x000002A7; busy high for exactly 16 cycles.
- −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000. Also 0x7FFFFFFF × 0x80000000 → hi=0xC0000000, lo=0x80000000.
- After a completed 6 × 7, launch 2 × 3 and assert start again at cycle 5 of RUN with operands 9 × 9 → the second start is ignored; the result is lo=6; previous product lo=42 is held until done.
- Back-to-back: start held high across done → the second operation's done arrives exactly 16 cycles after the first done, with the correct second product.
- clr pulsed mid-RUN at cycle 8 → busy, done, product_hi and product_lo all go to 0 immediately; no done appears afterward; a following start completes normally.
- 500 random signed operand pairs, including 0, −1, MIN and MAX → {product_hi, product_lo} equals $signed(M)·$signed(Q) at each done.
